// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: default widths, port id,
// command and read-tag structures.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  typedef logic port_id_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last granted port
// and the other port wins when both request.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_id_t last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    // No command may be accepted while reset is held.
    if (!rst_n) gnt = 2'b00;

    last_d = last_q;
    if (gnt[1])      last_d = 1'b1;
    else if (gnt[0]) last_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer in front of a single-port RAM: registers the winning
// command onto the RAM port and steers read data back with a tag pipeline.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [1:0] arb_gnt;
  logic       any_gnt;
  cmd_t       p0_cmd, p1_cmd, sel_cmd;
  rd_tag_t    tag_in, tag_out;

  rd_tag_t [RAM_RD_LAT:0] tag_q;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({p1_req, p0_req}),
    .gnt   (arb_gnt)
  );

  assign p0_gnt  = arb_gnt[0];
  assign p1_gnt  = arb_gnt[1];
  assign any_gnt = |arb_gnt;

  assign p0_cmd = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
  assign p1_cmd = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};

  always_comb begin
    sel_cmd = arb_gnt[1] ? p1_cmd : p0_cmd;
    tag_in  = '{valid: any_gnt && !sel_cmd.we, port: arb_gnt[1]};
  end

  // Address and data hold on idle cycles; only the write enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      we_q <= any_gnt && sel_cmd.we;
      if (any_gnt) begin
        addr_q <= sel_cmd.addr;
        din_q  <= sel_cmd.wdata;
      end
    end
  end

  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;

  // One stage covers the command register, the rest cover the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= '0;
    else        tag_q <= {tag_q[RAM_RD_LAT-1:0], tag_in};
  end

  assign tag_out = tag_q[RAM_RD_LAT];

  always_comb begin
    p0_rvalid = tag_out.valid && (tag_out.port == 1'b0);
    p1_rvalid = tag_out.valid && (tag_out.port == 1'b1);
    p0_rdata  = p0_rvalid ? ram_dout : '0;
    p1_rdata  = p1_rvalid ? ram_dout : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16x8 synchronous RAM
// (one cycle read latency) attached to the RAM port.
module tb_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [3:0] p0_addr, p1_addr;
  logic [7:0] p0_wdata, p1_wdata;
  logic       p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  logic [7:0] mem [16];
  logic [7:0] shadow [16];
  logic [3:0] raddr [20];
  int checks;
  int failures;
  int cnt0, cnt1;

  ram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},    {30'd0, p1_gnt, p0_gnt}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    chk({tag, "_rdata"},  {16'd0, p1_rdata, p0_rdata}, 32'd0);
    chk({tag, "_ram"},    {19'd0, ram_we, ram_addr, ram_din}, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    ram_dout = 8'h00;
    clear_inputs();
    rst_n = 1'b0;
    // Requests held during reset must not be granted.
    p0_req = 1'b1; p1_req = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");

    // Single port: write then read back, grant in the first cycle out of reset.
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 4'd3; p0_wdata = 8'hA5;
    #1 chk("t1_wr_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    @(negedge clk);
    #1 chk("t1_ram_port", {19'd0, ram_we, ram_addr, ram_din}, {19'd0, 1'b1, 4'd3, 8'hA5});
    p0_we = 1'b0; p0_wdata = 8'h00;
    #1 chk("t1_rd_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    @(negedge clk);
    clear_inputs();
    #1 chk("t1_no_early_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    @(negedge clk);
    #1 chk("t1_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd1);
    chk("t1_rdata", {24'd0, p0_rdata}, 32'hA5);
    chk("t1_p1_rdata", {24'd0, p1_rdata}, 32'h00);

    // Cross-port ordering: p1 write immediately followed by p0 read.
    @(negedge clk);
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 4'd7; p1_wdata = 8'h3C;
    #1 chk("xp_wr_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd2);
    @(negedge clk);
    clear_inputs();
    p0_req = 1'b1; p0_addr = 4'd7;
    #1 chk("xp_rd_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1 chk("xp_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd1);
    chk("xp_rdata", {24'd0, p0_rdata}, 32'h3C);

    // Back-to-back: fill all addresses, then 20 random reads with no bubbles.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      shadow[i] = 8'(i * 37 + 11);
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 4'(i); p0_wdata = shadow[i];
      #1 chk("b2b_wr_gnt", {31'd0, p0_gnt}, 32'd1);
    end
    for (int i = 0; i < 20; i++) raddr[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i < 20) begin
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = raddr[i]; p0_wdata = 8'h00;
      end else begin
        clear_inputs();
      end
      #1;
      if (i < 20) chk("b2b_rd_gnt", {31'd0, p0_gnt}, 32'd1);
      if (i >= 2) begin
        chk("b2b_rvalid", {31'd0, p0_rvalid}, 32'd1);
        chk("b2b_rdata", {24'd0, p0_rdata}, {24'd0, shadow[raddr[i-2]]});
      end else begin
        chk("b2b_rvalid_wr", {31'd0, p0_rvalid}, 32'd0);
      end
    end

    // Reset mid-flight: read granted, then reset while it is in the pipe.
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 4'd5;
    #1 chk("mf_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    @(negedge clk);
    p1_req = 1'b1;
    rst_n = 1'b0;
    #1 chk_reset_outputs("mf_reset");
    @(negedge clk);
    #1 chk_reset_outputs("mf_reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      #1 chk("mf_no_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
      @(negedge clk);
    end

    // Conflict: both ports read every cycle; p0 first, then strict alternation.
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 4'(i);
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 4'(15 - i);
      end else begin
        clear_inputs();
      end
      #1;
      if (i < 8) begin
        chk("cf_gnt", {30'd0, p1_gnt, p0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
        if (p0_gnt) cnt0++;
        if (p1_gnt) cnt1++;
      end
      if (i >= 2) begin
        if ((i - 2) % 2 == 0) begin
          chk("cf_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd1);
          chk("cf_rdata0", {16'd0, p1_rdata, p0_rdata}, {24'd0, shadow[i-2]});
        end else begin
          chk("cf_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd2);
          chk("cf_rdata1", {16'd0, p1_rdata, p0_rdata}, {16'd0, shadow[15-(i-2)], 8'd0});
        end
      end else begin
        chk("cf_rvalid_early", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
      end
      @(negedge clk);
    end
    chk("cf_p0_grants", cnt0, 32'd4);
    chk("cf_p1_grants", cnt1, 32'd4);

    // Idle: last grant was p1 to address 8, which must hold on the RAM port.
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_we", {31'd0, ram_we}, 32'd0);
      chk("idle_addr", {28'd0, ram_addr}, 32'd8);
      chk("idle_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
      chk("idle_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
